// File: rtl/fpu_pkg.sv
// Shared FPU definitions: normalizer FSM states and internal exponent sizing.
package fpu_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } norm_state_e;

    // Two guard bits let the biased exponent go negative and overshoot the max field value.
    localparam int NormExpGuardBits = 2;

    function automatic int norm_exp_width(input int exp_bits);
        return exp_bits + NormExpGuardBits;
    endfunction

endpackage

// File: rtl/fpu_utils_lzc.sv
// Combinational leading-zero counter; count equals Width when the input is all zero.
module fpu_utils_lzc #(
    parameter int Width    = 27,
    parameter int CntWidth = $clog2(Width + 1)
) (
    input  logic [Width-1:0]    data_i,
    output logic [CntWidth-1:0] count_o,
    output logic                all_zero_o
);

    // Scanning upward lets the highest set bit make the last assignment.
    always_comb begin
        count_o = CntWidth'(Width);
        for (int i = 0; i < Width; i++) begin
            if (data_i[i]) begin
                count_o = CntWidth'(Width - 1 - i);
            end
        end
    end

    assign all_zero_o = ~|data_i;

endmodule

// File: rtl/fpu_utils_normalize_seq.sv
// Iterative normalizer: shifts a wide magnitude by up to MaxShift bits per cycle,
// then packs {exp field, fraction} plus round/sticky for the rounder.
module fpu_utils_normalize_seq
    import fpu_pkg::*;
#(
    parameter int ExpBits  = 8,
    parameter int ManBits  = 23,
    parameter int InWidth  = 27,
    parameter int MaxShift = 8
) (
    input  logic                                      clk_i,
    input  logic                                      rst_ni,
    input  logic                                      in_valid_i,
    output logic                                      in_ready_o,
    input  logic [InWidth-1:0]                        mant_i,
    input  logic signed [norm_exp_width(ExpBits)-1:0] exp_i,
    input  logic                                      sign_i,
    input  logic                                      eff_sub_i,
    output logic                                      out_valid_o,
    input  logic                                      out_ready_i,
    output logic [ExpBits+ManBits-1:0]                abs_value_o,
    output logic [1:0]                                round_sticky_bits_o,
    output logic                                      sign_o,
    output logic                                      eff_sub_o,
    output logic                                      of_o
);

    localparam int ExpW    = norm_exp_width(ExpBits);
    localparam int LzcW    = $clog2(InWidth + 1);
    localparam int LowBits = InWidth - 2 - ManBits;
    localparam int ExpMax  = (2 ** ExpBits) - 1;

    norm_state_e                state_reg, state_next;
    logic [InWidth-1:0]         mant_reg, mant_next;
    logic signed [ExpW-1:0]     exp_reg, exp_next;
    logic                       sticky_reg, sticky_next;
    logic                       sign_reg, sign_next;
    logic                       eff_sub_reg, eff_sub_next;
    logic [ExpBits+ManBits-1:0] abs_reg, abs_next;
    logic [1:0]                 rs_reg, rs_next;
    logic                       of_reg, of_next;

    logic [LzcW-1:0]            lz_count;
    logic                       mant_zero;
    logic                       mant_msb;
    logic [InWidth-1:0]         lost_bits;
    logic [ExpBits+ManBits-1:0] pack_abs;
    logic [1:0]                 pack_rs;
    logic                       pack_of;
    int                         exp_int;
    int                         lz_int;
    int                         rsh;
    int                         lsh;

    fpu_utils_lzc #(
        .Width    (InWidth),
        .CntWidth (LzcW)
    ) u_lzc (
        .data_i     (mant_reg),
        .count_o    (lz_count),
        .all_zero_o (mant_zero)
    );

    assign mant_msb = mant_reg[InWidth-1];

    // Shift amounts and the packed result are evaluated from the current register contents.
    always_comb begin
        exp_int = 32'(exp_reg);
        lz_int  = 32'(lz_count);

        rsh = 1 - exp_int;
        if (rsh > MaxShift) rsh = MaxShift;

        lsh = lz_int;
        if (lsh > MaxShift) lsh = MaxShift;
        if (lsh > exp_int - 1) lsh = exp_int - 1;

        lost_bits = mant_reg & ~({InWidth{1'b1}} << rsh);

        pack_of = mant_msb && (exp_int >= ExpMax);
        if (pack_of) begin
            pack_abs = {{ExpBits{1'b1}}, {ManBits{1'b0}}};
            pack_rs  = 2'b00;
        end else begin
            pack_abs = {(mant_msb ? exp_reg[ExpBits-1:0] : {ExpBits{1'b0}}),
                        mant_reg[InWidth-2 -: ManBits]};
            pack_rs  = {mant_reg[LowBits], (|mant_reg[LowBits-1:0]) | sticky_reg};
        end
    end

    always_comb begin
        state_next   = state_reg;
        mant_next    = mant_reg;
        exp_next     = exp_reg;
        sticky_next  = sticky_reg;
        sign_next    = sign_reg;
        eff_sub_next = eff_sub_reg;
        abs_next     = abs_reg;
        rs_next      = rs_reg;
        of_next      = of_reg;

        case (state_reg)
            IDLE: begin
                if (in_valid_i) begin
                    mant_next    = mant_i;
                    exp_next     = exp_i;
                    sticky_next  = 1'b0;
                    sign_next    = sign_i;
                    eff_sub_next = eff_sub_i;
                    state_next   = SHIFT;
                end
            end
            SHIFT: begin
                if (!mant_zero && exp_int < 1) begin
                    // Underflow: move toward exponent 1, folding dropped bits into sticky.
                    mant_next   = mant_reg >> rsh;
                    sticky_next = sticky_reg | (|lost_bits);
                    exp_next    = ExpW'(exp_int + rsh);
                end else if (!mant_zero && !mant_msb && exp_int > 1) begin
                    mant_next = mant_reg << lsh;
                    exp_next  = ExpW'(exp_int - lsh);
                end else begin
                    abs_next   = pack_abs;
                    rs_next    = pack_rs;
                    of_next    = pack_of;
                    state_next = DONE;
                end
            end
            DONE: begin
                if (out_ready_i) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_reg   <= IDLE;
            mant_reg    <= '0;
            exp_reg     <= '0;
            sticky_reg  <= 1'b0;
            sign_reg    <= 1'b0;
            eff_sub_reg <= 1'b0;
            abs_reg     <= '0;
            rs_reg      <= '0;
            of_reg      <= 1'b0;
        end else begin
            state_reg   <= state_next;
            mant_reg    <= mant_next;
            exp_reg     <= exp_next;
            sticky_reg  <= sticky_next;
            sign_reg    <= sign_next;
            eff_sub_reg <= eff_sub_next;
            abs_reg     <= abs_next;
            rs_reg      <= rs_next;
            of_reg      <= of_next;
        end
    end

    assign in_ready_o          = (state_reg == IDLE);
    assign out_valid_o         = (state_reg == DONE);
    assign abs_value_o         = abs_reg;
    assign round_sticky_bits_o = rs_reg;
    assign sign_o              = sign_reg;
    assign eff_sub_o           = eff_sub_reg;
    assign of_o                = of_reg;

endmodule

// File: tb/tb_fpu_utils_normalize_seq.sv
// Randomized self-checking bench for fpu_utils_normalize_seq against a closed-form model.
module tb_fpu_utils_normalize_seq;

    localparam int ExpBits  = 8;
    localparam int ManBits  = 23;
    localparam int InWidth  = 27;
    localparam int MaxShift = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [26:0] mant = '0;
    logic [9:0]  exp_in = '0;
    logic        sign_in = 1'b0;
    logic        eff_in = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [30:0] abs_value;
    logic [1:0]  rs_bits;
    logic        sign_out;
    logic        eff_out;
    logic        of_out;

    int          checks_total = 0;
    int          checks_passed = 0;

    logic        armed = 1'b0;
    logic [30:0] exp_abs;
    logic [1:0]  exp_rs;
    logic        exp_of;
    logic        exp_sign;
    logic        exp_eff;

    fpu_utils_normalize_seq #(
        .ExpBits  (ExpBits),
        .ManBits  (ManBits),
        .InWidth  (InWidth),
        .MaxShift (MaxShift)
    ) dut (
        .clk_i               (clk),
        .rst_ni              (rst_n),
        .in_valid_i          (in_valid),
        .in_ready_o          (in_ready),
        .mant_i              (mant),
        .exp_i               (exp_in),
        .sign_i              (sign_in),
        .eff_sub_i           (eff_in),
        .out_valid_o         (out_valid),
        .out_ready_i         (out_ready),
        .abs_value_o         (abs_value),
        .round_sticky_bits_o (rs_bits),
        .sign_o              (sign_out),
        .eff_sub_o           (eff_out),
        .of_o                (of_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks_total++;
        if (act === req) checks_passed++;
        else $display("FAIL %s: got %h, expected %h", name, act, req);
    endtask

    // Closed-form result: total shift distance first, then pack; k is the number of shift cycles.
    function automatic void model(input logic [26:0] m, input int e,
                                  output logic [30:0] abs, output logic [1:0] rs,
                                  output logic of, output int k);
        logic [26:0] mm;
        logic [63:0] wide;
        int          ee;
        logic        st;
        int          d;
        int          lz;
        int          done_sh;
        mm = m; ee = e; st = 1'b0; k = 0;
        wide = {37'd0, m};
        if (m != 0) begin
            if (ee < 1) begin
                d = 1 - ee;
                done_sh = 0;
                while (done_sh < d && (wide >> done_sh) != 0) begin
                    k++;
                    done_sh = (done_sh + MaxShift < d) ? done_sh + MaxShift : d;
                end
                if (d >= InWidth) begin
                    st = 1'b1;
                    mm = '0;
                end else begin
                    st = ((wide & ((64'd1 << d) - 64'd1)) != 0);
                    mm = m >> d;
                end
                ee = 1;
            end else begin
                lz = 0;
                while (lz < InWidth && !mm[26-lz]) lz++;
                d = (lz < ee - 1) ? lz : ee - 1;
                mm = mm << d;
                ee = ee - d;
                k = (d + MaxShift - 1) / MaxShift;
            end
        end
        if (mm[26] && ee >= 255) begin
            of = 1'b1; abs = {8'hFF, 23'd0}; rs = 2'b00;
        end else begin
            of = 1'b0;
            abs = {(mm[26] ? 8'(ee) : 8'd0), mm[25:3]};
            rs = {mm[2], (|mm[1:0]) | st};
        end
    endfunction

    // Output compare: every cycle the result is presented, including back-pressure cycles.
    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            if (!armed) begin
                check("spurious_valid", 64'(out_valid), 64'd0);
            end else begin
                check("result", 64'({abs_value, rs_bits, of_out, sign_out, eff_out}),
                      64'({exp_abs, exp_rs, exp_of, exp_sign, exp_eff}));
                check("in_ready_in_done", 64'(in_ready), 64'd0);
            end
        end
    end

    task automatic do_op(input logic [26:0] m, input int e, input int hold, input logic garbage);
        int          k;
        int          n;
        logic [30:0] a;
        logic [1:0]  r;
        logic        o;
        @(negedge clk);
        check("in_ready_idle", 64'(in_ready), 64'd1);
        mant = m;
        exp_in = 10'(e);
        sign_in = 1'($urandom);
        eff_in = 1'($urandom);
        model(m, e, a, r, o, k);
        exp_abs = a; exp_rs = r; exp_of = o;
        exp_sign = sign_in; exp_eff = eff_in;
        armed = 1'b1;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = garbage;
        mant = 27'($urandom);
        exp_in = 10'($urandom);
        sign_in = ~sign_in;
        eff_in = ~eff_in;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!out_valid && n < 100);
        check("latency", 64'(n), 64'(k + 1));
        repeat (hold) @(negedge clk);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        check("idle_after_handshake", 64'({out_valid, in_ready}), 64'({1'b0, 1'b1}));
        armed = 1'b0;
    endtask

    task automatic pin(input string name, input logic [26:0] m, input int e,
                       input logic [30:0] ra, input logic [1:0] rr, input logic ro, input int rk);
        logic [30:0] a;
        logic [1:0]  r;
        logic        o;
        int          k;
        model(m, e, a, r, o, k);
        check(name, 64'({a, r, o, 8'(k)}), 64'({ra, rr, ro, 8'(rk)}));
    endtask

    initial begin
        logic [26:0] rm;
        int          re;
        int          sel;

        // Hand-derived expectations fixing the model.
        pin("pin_noshift", 27'h4000000, 127, {8'd127, 23'd0}, 2'b00, 1'b0, 0);
        pin("pin_multileft", 27'h0000001, 127, {8'd101, 23'd0}, 2'b00, 1'b0, 4);
        pin("pin_rs11", 27'h4000007, 127, {8'd127, 23'd0}, 2'b11, 1'b0, 0);
        pin("pin_rs10", 27'h4000004, 127, {8'd127, 23'd0}, 2'b10, 1'b0, 0);
        pin("pin_explimit", 27'h0000001, 3, {8'd0, 23'd0}, 2'b10, 1'b0, 1);
        pin("pin_subnormal", 27'h4000000, -2, {8'd0, 23'h100000}, 2'b00, 1'b0, 1);
        pin("pin_overflow", 27'h4000000, 255, {8'hFF, 23'd0}, 2'b00, 1'b1, 0);
        pin("pin_zero", 27'h0000000, 77, 31'd0, 2'b00, 1'b0, 0);
        pin("pin_underflow_sticky", 27'h0000003, -40, 31'd0, 2'b01, 1'b0, 1);

        #1 rst_n = 1'b0;
        #1;
        check("reset_outputs", 64'({in_ready, out_valid, abs_value, rs_bits, sign_out, eff_out, of_out}),
              64'({1'b1, 1'b0, 31'd0, 2'b00, 1'b0, 1'b0, 1'b0}));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        do_op(27'h4000000, 127, 0, 1'b0);
        do_op(27'h0000001, 127, 1, 1'b0);
        do_op(27'h4000007, 127, 0, 1'b1);
        do_op(27'h4000004, 127, 0, 1'b0);
        do_op(27'h0000001, 3, 0, 1'b0);
        do_op(27'h4000000, -2, 0, 1'b0);
        do_op(27'h4000000, 255, 0, 1'b0);
        do_op(27'h0000000, -100, 0, 1'b0);
        do_op(27'h0000001, -300, 2, 1'b1);
        do_op(27'h5A5A5A5, 60, 5, 1'b1);

        // Reset while shifting aborts the operation without waiting for a clock edge.
        @(negedge clk);
        mant = 27'h0000001; exp_in = 10'd127; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midshift_reset", 64'({out_valid, in_ready, abs_value, of_out}),
              64'({1'b0, 1'b1, 31'd0, 1'b0}));
        @(negedge clk);
        rst_n = 1'b1;

        for (int t = 0; t < 250; t++) begin
            rm = 27'($urandom);
            rm = rm >> $urandom_range(0, 27);
            if ($urandom_range(0, 15) == 0) rm = '0;
            sel = int'($urandom_range(0, 9));
            case (sel)
                0: re = int'($urandom_range(0, 1023)) - 512;
                1: re = int'($urandom_range(240, 270));
                2: re = int'($urandom_range(0, 32)) - 30;
                default: re = int'($urandom_range(1, 200));
            endcase
            do_op(rm, re, int'($urandom_range(0, 3)), 1'($urandom));
        end

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
